// File: rtl/encoder8_3_pkg.sv
// Shared widths, state encoding and a one-hot helper for the 8-to-3 request encoder.
package encoder8_3_pkg;

  localparam int REQ_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [REQ_W-1:0] onehot(input logic [IDX_W-1:0] i);
    return REQ_W'(1) << i;
  endfunction

endpackage

// File: rtl/encoder8_3_pri_sel8.sv
// Combinational circular search: first set bit of elig at or after start, wrapping 7->0.
// Latency: none. Backpressure: none.
module pri_sel8
  import encoder8_3_pkg::*;
(
  input  logic [REQ_W-1:0] elig,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] k;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    found = 1'b0;
    idx   = start;
    k     = start;
    for (int n = REQ_W - 1; n >= 0; n--) begin
      k = start + IDX_W'(n);
      if (elig[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/encoder8_3.sv
// Pending-request encoder: offers one index per cycle; fixed priority, or round-robin with ENCODER_RR_EN.
// Latency: 2 edges from req_i sample to valid_o. Backpressure: offer holds stable while ready_i=0.
module encoder8_3
  import encoder8_3_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req_i,
  input  logic [REQ_W-1:0] mask_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [REQ_W-1:0] pending_o
);

  state_t           state;
  logic             acc;
  logic [REQ_W-1:0] clr;
  logic [REQ_W-1:0] elig;
  logic [IDX_W-1:0] start;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;

  assign acc  = valid_o && ready_i;
  assign clr  = acc ? onehot(idx_o) : '0;
  assign elig = pending_o & ~mask_i & ~clr;

`ifdef ENCODER_RR_EN
  logic [IDX_W-1:0] ptr;

  // On acceptance the search already starts past the index being accepted.
  assign start = (acc ? idx_o : ptr) + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'h7;
    end else if (acc) begin
      ptr <= idx_o;
    end
  end
`else
  assign start = '0;
`endif

  pri_sel8 u_sel (
    .elig  (elig),
    .start (start),
    .found (sel_vld),
    .idx   (sel_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_o   <= 1'b0;
      idx_o     <= '0;
      pending_o <= '0;
    end else begin
      pending_o <= (pending_o & ~clr) | req_i;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            state   <= OFFER;
            valid_o <= 1'b1;
            idx_o   <= sel_idx;
          end
        end
        OFFER: begin
          if (ready_i) begin
            if (sel_vld) begin
              idx_o <= sel_idx;
            end else begin
              state   <= IDLE;
              valid_o <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder8_3.sv
// Scoreboarded bench for encoder8_3: directed scenarios plus random traffic against a queue-fed reference model.
module tb_encoder8_3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_i;
  logic [7:0] mask_i;
  logic       ready_i;
  logic       valid_o;
  logic [2:0] idx_o;
  logic [7:0] pending_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
    logic [7:0] pend;
  } exp_t;

  exp_t sb_q[$];

  // reference model state: what the outputs should be right now
  logic [7:0] m_pend;
  logic       m_vld;
  int         m_idx;
  int         m_ptr;

  encoder8_3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .mask_i    (mask_i),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .idx_o     (idx_o),
    .pending_o (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 8'h00;
    m_vld  = 1'b0;
    m_idx  = 0;
    m_ptr  = 7;
  endtask

  // Advance the model by one clock edge given this cycle's inputs.
  task automatic model_step(input logic [7:0] req, input logic [7:0] mask, input logic rdy);
    logic       acc;
    logic [7:0] nxt;
    int         pick;
    int         base;
    int         k;
    acc  = m_vld && rdy;
    pick = -1;
    for (int b = 0; b < 8; b++)
      nxt[b] = (m_pend[b] && !(acc && b == m_idx)) || req[b];
    if (acc) m_ptr = m_idx;
    if (!(m_vld && !rdy)) begin
`ifdef ENCODER_RR_EN
      base = (m_ptr + 1) % 8;
`else
      base = 0;
`endif
      for (int n = 0; n < 8; n++) begin
        k = (base + n) % 8;
        if (pick < 0 && m_pend[k] && !mask[k] && !(acc && k == m_idx)) pick = k;
      end
      if (pick >= 0) begin
        m_vld = 1'b1;
        m_idx = pick;
      end else begin
        m_vld = 1'b0;
      end
    end
    m_pend = nxt;
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, return just after the edge.
  task automatic cycle(input logic [7:0] req, input logic [7:0] mask, input logic rdy);
    exp_t e;
    @(negedge clk);
    req_i   = req;
    mask_i  = mask;
    ready_i = rdy;
    model_step(req, mask, rdy);
    e.vld  = m_vld;
    e.idx  = 3'(m_idx);
    e.pend = m_pend;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 16 && (m_vld || m_pend != 8'h00); n++) cycle(8'h00, 8'h00, 1'b1);
    chk("drain_valid", int'(valid_o), 0);
    chk("drain_pending", int'(pending_o), 0);
  endtask

  task automatic expect_offer(input string name, input int idx);
    chk({name, "_valid"}, int'(valid_o), 1);
    chk({name, "_idx"}, int'(idx_o), idx);
  endtask

  // monitor: compares the DUT against every queued expectation, away from the edge
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_valid", int'(valid_o), int'(e.vld));
      if (e.vld) chk("sb_idx", int'(idx_o), int'(e.idx));
      chk("sb_pending", int'(pending_o), int'(e.pend));
    end
  end

  initial begin
    int seq[3];
    seq = '{0, 4, 7};
    rst_n   = 1'b0;
    req_i   = 8'hFF;
    mask_i  = 8'h00;
    ready_i = 1'b0;
    model_reset();

    #1;
    chk("rst_async_pending", int'(pending_o), 0);
    chk("rst_async_valid", int'(valid_o), 0);
    chk("rst_async_idx", int'(idx_o), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_pending", int'(pending_o), 0);
      chk("rst_valid", int'(valid_o), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_i = 8'h00;

    // priority drain straight out of reset
    cycle(8'h91, 8'h00, 1'b1);
    chk("drain91_pending", int'(pending_o), 8'h91);
    chk("drain91_idle", int'(valid_o), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 8'h00, 1'b1);
      expect_offer("drain91_seq", seq[i]);
    end
    cycle(8'h00, 8'h00, 1'b1);
    chk("drain91_end", int'(valid_o), 0);

    // two-edge latency, then an unaccepted offer holds against any disturbance
    cycle(8'h20, 8'h00, 1'b0);
    chk("lat_edge1", int'(valid_o), 0);
    cycle(8'h00, 8'h00, 1'b0);
    expect_offer("lat_edge2", 5);
    for (int i = 0; i < 6; i++) begin
      cycle(8'(($urandom % 255) + 1), 8'($urandom), 1'b0);
      expect_offer("hold", 5);
    end
    drain();

    // hold while a higher priority arrives, then mask keeps bit 3 out
    cycle(8'h08, 8'h00, 1'b0);
    cycle(8'h00, 8'h00, 1'b0);
    expect_offer("mask_first", 3);
    repeat (3) begin
      cycle(8'h01, 8'h08, 1'b0);
      expect_offer("mask_hold", 3);
    end
    cycle(8'h08, 8'h08, 1'b1);
    expect_offer("mask_next", 0);
    chk("mask_pend_kept", int'(pending_o), 8'h09);
    cycle(8'h00, 8'h08, 1'b1);
    chk("mask_blocked", int'(valid_o), 0);
    chk("mask_pend", int'(pending_o), 8'h08);
    cycle(8'h00, 8'h08, 1'b1);
    chk("mask_still_blocked", int'(valid_o), 0);
    cycle(8'h00, 8'h00, 1'b0);
    expect_offer("mask_release", 3);
    drain();

    // accept and re-request the same bit in one cycle
    cycle(8'h04, 8'h00, 1'b0);
    cycle(8'h00, 8'h00, 1'b0);
    expect_offer("simul_first", 2);
    cycle(8'h04, 8'h00, 1'b1);
    chk("simul_pend", int'(pending_o), 8'h04);
    cycle(8'h00, 8'h00, 1'b0);
    expect_offer("simul_reoffer", 2);
    drain();

`ifdef ENCODER_RR_EN
    cycle(8'h40, 8'h00, 1'b0);
    cycle(8'h00, 8'h00, 1'b0);
    expect_offer("rr_set6", 6);
    cycle(8'h00, 8'h00, 1'b1);
    cycle(8'h41, 8'h00, 1'b0);
    cycle(8'h00, 8'h00, 1'b0);
    expect_offer("rr_wrap0", 0);
    cycle(8'h00, 8'h00, 1'b1);
    expect_offer("rr_wrap6", 6);
    drain();
`endif

    // random traffic, checked only by the scoreboard
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4 == 0) ? 8'($urandom) : 8'h00,
            ($urandom % 3 == 0) ? 8'($urandom) : 8'h00,
            1'($urandom % 2));
    end
    drain();

    // asynchronous reset in the middle of an offer
    cycle(8'hFF, 8'h00, 1'b0);
    cycle(8'h00, 8'h00, 1'b0);
    expect_offer("midrst_pre", 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_pending", int'(pending_o), 0);
    chk("midrst_idx", int'(idx_o), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h02, 8'h00, 1'b0);
    chk("postrst_pend", int'(pending_o), 8'h02);
    cycle(8'h00, 8'h00, 1'b0);
    expect_offer("postrst_offer", 1);
    drain();

    repeat (2) @(posedge clk);
    #3;
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder8_3.md
ENCODER8_3 -- requirements
Module: encoder8_3

Interface
REQ-001 Parameters: none; the block SHALL be fixed at 8 request lines and a 3-bit index.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_i  input  8  request pulses or levels; bit k requests index k.
REQ-005 mask_i  input  8  bit k high SHALL block bit k from selection, but SHALL NOT clear its pending state.
REQ-006 ready_i  input  1  consumer accepts the offered index.
REQ-007 valid_o  output  1  an index is offered.
REQ-008 idx_o  output  3  binary index of the offered request.
REQ-009 pending_o  output  8  registered pending-request vector.

Function
REQ-010 Each cycle, pending SHALL update as (pending & ~clr) | req_i, where clr = one-hot(idx_o) when valid_o && ready_i, else 0.
REQ-011 A set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-012 The block SHALL have two states: IDLE (valid_o=0) and OFFER (valid_o=1).
REQ-013 Eligible set SHALL be pending & ~mask_i & ~clr, evaluated in the current cycle.
REQ-014 IDLE -> OFFER when eligible is nonzero; idx_o SHALL load the selected index on that edge.
REQ-015 Latency SHALL be 2 edges from req_i being sampled to valid_o=1: edge 1 sets pending, edge 2 offers.
REQ-016 In OFFER with ready_i=0, idx_o and valid_o SHALL hold stable, regardless of new requests, mask changes or higher-priority arrivals.
REQ-017 In OFFER with ready_i=1, the block SHALL clear the accepted bit.
REQ-018 In OFFER with ready_i=1, the block SHALL stay in OFFER, loading the next selection from the eligible set, if that set is nonzero; otherwise it SHALL go to IDLE.
REQ-019 Back-to-back acceptance SHALL sustain one index per cycle.
REQ-020 Fixed priority (default): the lowest eligible index SHALL win.
REQ-021 ready_i in IDLE SHALL be ignored.
REQ-022 idx_o SHALL retain its last value when valid_o=0.

Reset
REQ-023 While rst_n=0, the block SHALL set pending_o=8'h00, valid_o=0 and idx_o=3'h0, and enter IDLE immediately, without waiting for clk.
REQ-024 Reset mid-offer SHALL drop the offer and all pending requests; no acceptance SHALL be recorded.
REQ-025 The first edge after rst_n deasserts SHALL sample req_i normally.

Configuration
REQ-026 Macro ENCODER_RR_EN defined: selection SHALL be round-robin.
REQ-027 In round-robin mode, a 3-bit pointer SHALL hold the last accepted index, with reset value 3'h7.
REQ-028 In round-robin mode, the search SHALL start at pointer+1, wrap 7->0, and take the first eligible index.
REQ-029 In round-robin mode, the pointer SHALL update only on acceptance (valid_o && ready_i).
REQ-030 Macro ENCODER_RR_EN undefined: the block SHALL use fixed priority per REQ-020, and no pointer register SHALL exist.

Structure
REQ-031 A shared package SHALL hold the widths (REQ_W=8, IDX_W=3) and the state enum (IDLE, OFFER).
REQ-032 Sub-module pri_sel8 SHALL be combinational: eligible vector plus start index in, found flag plus index out.
REQ-033 Fixed mode SHALL tie the pri_sel8 start index to 0.

Verification
REQ-034 Reset: rst_n=0 for 3 cycles with req_i=8'hFF -> pending_o=8'h00, valid_o=0.
REQ-035 Latency: req_i=8'h20 pulsed 1 cycle, ready_i=0 -> valid_o=1, idx_o=5 two edges later, held indefinitely.
REQ-036 Priority drain: req_i=8'h91 pulsed, ready_i=1 -> fixed mode idx_o sequence 0,4,7 on consecutive cycles, then valid_o=0; with ENCODER_RR_EN the sequence is also 0,4,7 from reset.
REQ-037 Hold/mask: offer idx 3 held with ready_i=0, then req_i=8'h01 and mask_i=8'h08 -> idx_o stays 3 until accepted, then idx_o=0; bit 3 is not re-offered while masked.
REQ-038 Simultaneous: accept idx 2 while req_i=8'h04 in the same cycle -> pending_o[2] stays 1 and idx 2 is re-offered.
REQ-039 Round-robin wrap (ENCODER_RR_EN): pointer=6, pending=8'h41 -> idx_o=0, then 6.
